// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId state, interrupt/exception request, mfc0/mtc0/eret.
// Optional BadVAddr register (reg 8) and BadVAddrIn port when CP0_BADVADDR_EN is defined.
module cp0 #(
   parameter logic [31:0] PRID_VALUE = 32'h2206_0007,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  CP0Add,
   input  logic [31:0] CP0In,
   output logic [31:0] CP0Out,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
`ifdef CP0_BADVADDR_EN
   input  logic [31:0] BadVAddrIn,
`endif
   output logic [31:0] EPCOut,
   output logic [31:0] HandlerPC,
   output logic        Req
);

   logic [5:0]  im_reg;
   logic        exl_reg;
   logic        ie_reg;
   logic        bd_reg;
   logic [5:0]  ip_reg;
   logic [4:0]  exc_code_reg;
   logic [31:0] epc_reg;
`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_reg;
`endif

   logic        int_req;
   logic        exc_req;
   logic [31:0] pc_aligned;
   logic [31:0] epc_next;

   // Live HWInt (not IP) so an interrupt edge is taken in the same cycle.
   assign int_req    = (|(HWInt & im_reg)) & ie_reg & ~exl_reg;
   assign exc_req    = (ExcCodeIn != 5'd0) & ~exl_reg;
   assign Req        = int_req | exc_req;
   assign pc_aligned = VPC & ~32'd3;
   assign epc_next   = BDIn ? pc_aligned - 32'd4 : pc_aligned;
   assign EPCOut     = epc_reg;
   assign HandlerPC  = HANDLER_PC;

   always_ff @(posedge clk) begin
      if (reset) begin
         im_reg       <= '0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         ip_reg       <= '0;
         exc_code_reg <= '0;
         epc_reg      <= '0;
`ifdef CP0_BADVADDR_EN
         badvaddr_reg <= '0;
`endif
      end else begin
         ip_reg <= HWInt;
         if (Req) begin
            exl_reg      <= 1'b1;
            bd_reg       <= BDIn;
            exc_code_reg <= int_req ? 5'd0 : ExcCodeIn;
            epc_reg      <= epc_next;
`ifdef CP0_BADVADDR_EN
            if (!int_req && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5))
               badvaddr_reg <= BadVAddrIn;
`endif
         end else if (EXLClr) begin
            exl_reg <= 1'b0;
         end else if (en) begin
            if (CP0Add == 5'd12) begin
               im_reg  <= CP0In[15:10];
               exl_reg <= CP0In[1];
               ie_reg  <= CP0In[0];
            end else if (CP0Add == 5'd14) begin
               epc_reg <= CP0In;
            end
         end
      end
   end

   always_comb begin
      CP0Out = '0;
      case (CP0Add)
`ifdef CP0_BADVADDR_EN
         5'd8:    CP0Out = badvaddr_reg;
`endif
         5'd12:   CP0Out = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
         5'd13:   CP0Out = {bd_reg, 15'd0, ip_reg, 3'd0, exc_code_reg, 2'd0};
         5'd14:   CP0Out = epc_reg;
         5'd15:   CP0Out = PRID_VALUE;
         default: CP0Out = '0;
      endcase
   end

endmodule
